// File: rtl/life_pkg.sv
// Shared types, default rules and the cell update rule for the life grid engine.
package life_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_e;

   // Conway B3/S23 as the default rule pair.
   localparam logic [8:0] DEF_BIRTH   = 9'b000001000;
   localparam logic [8:0] DEF_SURVIVE = 9'b000001100;

   // Next state of one cell: live cells look up SURVIVE, dead cells look up BIRTH.
   function automatic logic cell_next(input logic [3:0] count,
                                      input logic       cur,
                                      input logic [8:0] birth,
                                      input logic [8:0] survive);
      logic [15:0] rule;
      // Zero-extended so every 4-bit count is a legal index; counts above 8 never occur.
      rule = cur ? {7'd0, survive} : {7'd0, birth};
      return rule[count];
   endfunction

endpackage

// File: rtl/life_row_calc.sv
// Combinational evaluation of one grid row from its vertical neighbours.
module life_row_calc
   import life_pkg::*;
#(
   parameter int         COLS    = 8,
   parameter bit         WRAP    = 1'b0,
   parameter logic [8:0] BIRTH   = DEF_BIRTH,
   parameter logic [8:0] SURVIVE = DEF_SURVIVE
) (
   input  logic [COLS-1:0] above_i,
   input  logic [COLS-1:0] cur_i,
   input  logic [COLS-1:0] below_i,
   output logic [COLS-1:0] next_o
);

   // Rows extended by one guard column on each side: bit j holds column j-1.
   // The guards carry either the opposite edge (torus) or a dead cell.
   logic [COLS+1:0] above_x, cur_x, below_x;

   assign above_x = WRAP ? {above_i[0], above_i, above_i[COLS-1]} : {1'b0, above_i, 1'b0};
   assign cur_x   = WRAP ? {cur_i[0],   cur_i,   cur_i[COLS-1]}   : {1'b0, cur_i,   1'b0};
   assign below_x = WRAP ? {below_i[0], below_i, below_i[COLS-1]} : {1'b0, below_i, 1'b0};

   for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] count;

      // Column c sits at guard index c+1, so its neighbours are at c and c+2.
      assign count = 4'(above_x[c]) + 4'(above_x[c+1]) + 4'(above_x[c+2])
                   + 4'(cur_x[c])                      + 4'(cur_x[c+2])
                   + 4'(below_x[c]) + 4'(below_x[c+1]) + 4'(below_x[c+2]);

      assign next_o[c] = cell_next(count, cur_i[c], BIRTH, SURVIVE);
   end

endmodule

// File: rtl/life_grid_engine.sv
// Cellular-automaton engine: serial cell programming, one row per clock per generation.
module life_grid_engine
   import life_pkg::*;
#(
   parameter int         ROWS    = 8,
   parameter int         COLS    = 8,
   parameter bit         WRAP    = 1'b0,
   parameter logic [8:0] BIRTH   = DEF_BIRTH,
   parameter logic [8:0] SURVIVE = DEF_SURVIVE,
   parameter int         GEN_W   = 16
) (
   input  logic                 clka,
   input  logic                 stop_n,
   input  logic                 clear,
   input  logic                 prog_valid,
   input  logic                 prog_bit,
   input  logic                 step,
   output logic                 ready,
   output logic                 done,
   output logic [ROWS*COLS-1:0] grid,
   output logic [GEN_W-1:0]     gen_count,
   output logic                 stable,
   output logic                 extinct
);

   localparam int CELLS = ROWS * COLS;
   localparam int CW    = $clog2(CELLS);
   localparam int RW    = $clog2(ROWS);

   state_e             state_q;
   logic [CELLS-1:0]   grid_q;
   logic [CELLS-1:0]   next_q;
   logic [CW-1:0]      cursor_q;
   logic [RW-1:0]      row_q;
   logic [GEN_W-1:0]   gen_q;
   logic               done_q;
   logic               stable_q;
   logic               extinct_q;

   logic [COLS-1:0]    above_d, cur_d, below_d, row_next_d;
   logic [CELLS-1:0]   commit_d;
   logic [CELLS-1:0]   prog_grid_d;
   logic               last_row;

   assign last_row = (row_q == RW'(ROWS - 1));

   // Select the rows around row_q; the vertical edge rule is applied here.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      above_d = '0;
      below_d = '0;
      cur_d   = grid_q[int'(row_q)*COLS +: COLS];
      if (row_q != '0)
         above_d = grid_q[(int'(row_q) - 1)*COLS +: COLS];
      else if (WRAP)
         above_d = grid_q[(ROWS - 1)*COLS +: COLS];
      if (!last_row)
         below_d = grid_q[(int'(row_q) + 1)*COLS +: COLS];
      else if (WRAP)
         below_d = grid_q[0 +: COLS];
   end

   life_row_calc #(
      .COLS    (COLS),
      .WRAP    (WRAP),
      .BIRTH   (BIRTH),
      .SURVIVE (SURVIVE)
   ) u_row_calc (
      .above_i (above_d),
      .cur_i   (cur_d),
      .below_i (below_d),
      .next_o  (row_next_d)
   );

   // Full next generation as it stands once the current row is merged in, and the grid after a prog write.
   always_comb begin
      commit_d = next_q;
      commit_d[int'(row_q)*COLS +: COLS] = row_next_d;
      prog_grid_d = grid_q;
      prog_grid_d[cursor_q] = prog_bit;
   end

   // Control FSM with the grid, next buffer and all status registers.
   always_ff @(posedge clka) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!stop_n || clear) begin
         // NOTE: the next buffer is a plain register array, so clearing it here is cheap and keeps it defined.
         state_q   <= IDLE;
         grid_q    <= '0;
         next_q    <= '0;
         cursor_q  <= '0;
         row_q     <= '0;
         gen_q     <= '0;
         done_q    <= 1'b0;
         stable_q  <= 1'b0;
         extinct_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (step) begin
                  state_q <= CALC;
                  row_q   <= '0;
               end else if (prog_valid) begin
                  grid_q    <= prog_grid_d;
                  extinct_q <= ~|prog_grid_d;
                  cursor_q  <= (cursor_q == CW'(CELLS - 1)) ? '0 : cursor_q + CW'(1);
               end
            end
            CALC: begin
               next_q[int'(row_q)*COLS +: COLS] <= row_next_d;
               if (last_row) begin
                  grid_q    <= commit_d;
                  stable_q  <= (commit_d == grid_q);
                  extinct_q <= ~|commit_d;
                  gen_q     <= gen_q + GEN_W'(1);
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  row_q <= row_q + RW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready     = (state_q == IDLE);
   assign done      = done_q;
   assign grid      = grid_q;
   assign gen_count = gen_q;
   assign stable    = stable_q;
   assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: dead-edge and toroidal 8x8 engines driven in parallel against an array model.
module tb_life_grid_engine;

   logic        clka = 1'b0;
   logic        stop_n, clear, prog_valid, prog_bit, step;
   logic        ready0, done0, stable0, extinct0;
   logic        ready1, done1, stable1, extinct1;
   logic [63:0] grid0, grid1;
   logic [15:0] gen0, gen1;

   int          n_checks = 0;
   int          n_pass   = 0;

   // Reference state, index 0 = dead edges, 1 = torus.
   logic [63:0] m_grid [2];
   logic        m_stable [2];
   logic        m_extinct [2];
   logic [15:0] m_gen;

   localparam logic [63:0] GLIDER = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);

   always #5 clka = ~clka;

   life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1'b0)) dut0 (
      .clka(clka), .stop_n(stop_n), .clear(clear), .prog_valid(prog_valid), .prog_bit(prog_bit),
      .step(step), .ready(ready0), .done(done0), .grid(grid0), .gen_count(gen0),
      .stable(stable0), .extinct(extinct0));

   life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1'b1)) dut1 (
      .clka(clka), .stop_n(stop_n), .clear(clear), .prog_valid(prog_valid), .prog_bit(prog_bit),
      .step(step), .ready(ready1), .done(done1), .grid(grid1), .gen_count(gen1),
      .stable(stable1), .extinct(extinct1));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   // Conway B3/S23 on an 8x8 board, counted directly from coordinates.
   function automatic logic [63:0] next_gen(input logic [63:0] g, input bit wrap);
      logic [63:0] n;
      int cnt, rr, cc;
      n = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     rr = r + dr;
                     cc = c + dc;
                     if (wrap) begin
                        rr = (rr + 8) % 8;
                        cc = (cc + 8) % 8;
                        cnt += int'(g[rr*8 + cc]);
                     end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                        cnt += int'(g[rr*8 + cc]);
                     end
                  end
               end
            end
            n[r*8 + c] = (cnt == 3) || (g[r*8 + c] && cnt == 2);
         end
      end
      return n;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_grid[k]    = '0;
         m_stable[k]  = 1'b0;
         m_extinct[k] = 1'b1;
      end
      m_gen = '0;
   endtask

   task automatic model_step();
      logic [63:0] n;
      for (int k = 0; k < 2; k++) begin
         n            = next_gen(m_grid[k], k == 1);
         m_stable[k]  = (n == m_grid[k]);
         m_extinct[k] = (n == 64'd0);
         m_grid[k]    = n;
      end
      m_gen = m_gen + 16'd1;
   endtask

   task automatic compare_all(input string tag);
      check({tag, "/grid0"},    grid0,    m_grid[0]);
      check({tag, "/grid1"},    grid1,    m_grid[1]);
      check({tag, "/gen0"},     64'(gen0), 64'(m_gen));
      check({tag, "/gen1"},     64'(gen1), 64'(m_gen));
      check({tag, "/stable0"},  64'(stable0),  64'(m_stable[0]));
      check({tag, "/stable1"},  64'(stable1),  64'(m_stable[1]));
      check({tag, "/extinct0"}, 64'(extinct0), 64'(m_extinct[0]));
      check({tag, "/extinct1"}, 64'(extinct1), 64'(m_extinct[1]));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_reset();
   endtask

   // Serial write at the cursor; the model grid is updated only for an idle engine.
   task automatic prog(input logic b, input int idx);
      prog_valid = 1'b1;
      prog_bit   = b;
      tick();
      prog_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_grid[k][idx] = b;
         m_extinct[k]   = (m_grid[k] == 64'd0);
      end
   endtask

   task automatic load(input logic [63:0] pat);
      do_clear();
      for (int i = 0; i < 64; i++) prog(pat[i], i);
   endtask

   // Bounded wait for done; returns the number of edges waited.
   task automatic wait_done(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!done0 && cycles < 40);
   endtask

   task automatic run_step(input string tag);
      int cycles;
      step = 1'b1;
      tick();
      step = 1'b0;
      check({tag, "/busy"}, 64'(ready0), 64'd0);
      wait_done(cycles);
      check({tag, "/latency"}, 64'(cycles), 64'd8);
      check({tag, "/done1"}, 64'(done1), 64'd1);
      check({tag, "/ready_done"}, 64'(ready0), 64'd1);
      model_step();
      compare_all(tag);
      tick();
      check({tag, "/done_pulse"}, 64'(done0), 64'd0);
   endtask

   initial begin
      int          cycles;
      int          pulses;
      logic [63:0] pat;

      stop_n = 1'b0; clear = 1'b0; prog_valid = 1'b0; prog_bit = 1'b0; step = 1'b0;
      model_reset();
      tick();
      tick();
      stop_n = 1'b1;
      check("rst/ready", 64'(ready0), 64'd1);
      check("rst/done",  64'(done0),  64'd0);
      compare_all("rst");

      // Blinker, both phases.
      load((64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
      run_step("blink1");
      check("blink1/spec", grid0, (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35));
      run_step("blink2");
      check("blink2/spec", grid0, (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));

      // Block still life.
      load((64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18));
      run_step("block");
      check("block/spec", grid0, (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18));
      check("block/stable", 64'(stable0), 64'd1);

      // Single column on the top/bottom edge.
      load((64'd1 << 0) | (64'd1 << 8) | (64'd1 << 56));
      run_step("edge");
      check("edge/dead", grid0, 64'd0);
      check("edge/extinct", 64'(extinct0), 64'd1);

      // Glider with step held: one generation every 9 cycles, period 32 on the torus.
      load(GLIDER);
      step = 1'b1;
      tick();
      for (int g = 0; g < 32; g++) begin
         wait_done(cycles);
         check($sformatf("glider/lat%0d", g), 64'(cycles), (g == 0) ? 64'd8 : 64'd9);
         model_step();
         if (g == 31) step = 1'b0;
      end
      compare_all("glider");
      check("glider/home", grid1, GLIDER);
      check("glider/gen", 64'(gen1), 64'd32);
      tick();

      // Step and prog during CALC are ignored.
      load((64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      step = 1'b1; prog_valid = 1'b1; prog_bit = 1'b1;
      tick();
      step = 1'b0; prog_valid = 1'b0;
      wait_done(cycles);
      check("hs/done", 64'(done0), 64'd1);
      model_step();
      for (int i = 0; i < 12; i++) tick();
      compare_all("hs");
      prog(1'b1, 0);
      compare_all("hs_cursor");

      // Clear on CALC cycle 3.
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_reset();
      check("clr/ready", 64'(ready0), 64'd1);
      check("clr/done", 64'(done0), 64'd0);
      compare_all("clr");
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done0 || done1) pulses++;
      end
      check("clr/no_done", 64'(pulses), 64'd0);

      // Cursor wrap: 65 ones, then a zero that must land on bit 1.
      for (int i = 0; i < 65; i++) prog(1'b1, i % 64);
      prog(1'b0, 1);
      check("wrap/spec", grid0, ~(64'd1 << 1));
      compare_all("wrap");

      // Random soups, a few generations each.
      for (int r = 0; r < 6; r++) begin
         pat = {$urandom(), $urandom()};
         if (r % 2 == 0) pat = pat & {$urandom(), $urandom()};
         load(pat);
         for (int s = 0; s < 3; s++) run_step($sformatf("rnd%0d_%0d", r, s));
      end

      // Reset in the middle of CALC.
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      stop_n = 1'b0;
      tick();
      stop_n = 1'b1;
      model_reset();
      check("rst2/ready", 64'(ready0), 64'd1);
      check("rst2/done", 64'(done0), 64'd0);
      compare_all("rst2");
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done0 || done1) pulses++;
      end
      check("rst2/no_done", 64'(pulses), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
